// File: rtl/rib_pkg.sv
// Shared constants and helpers for the RIB interconnect.
package rib_pkg;

   localparam logic RIB_REQ = 1'b1;
   localparam logic RIB_WE  = 1'b1;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Bit width needed to hold values 0..n-1, never less than one bit.
   function automatic int rib_clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rib_arb.sv
// Request arbiter: fixed priority (highest index wins) or round-robin from a start pointer.
module rib_arb
   import rib_pkg::*;
#(
   parameter int NUM_M    = 3,
   parameter int ARB_MODE = ARB_FIXED,
   parameter int IDW      = rib_clog2(NUM_M)
) (
   input  logic [NUM_M-1:0] i_req,
   input  logic [IDW-1:0]   i_rr_ptr,
   output logic [NUM_M-1:0] o_gnt_oh,
   output logic [IDW-1:0]   o_gnt_id,
   output logic             o_gnt_v
);

   int w_start;

   // Scan downward: fixed mode keeps the first hit (highest index),
   // round-robin keeps the last hit (closest at/above the pointer).
   always_comb begin
      o_gnt_id = '0;
      o_gnt_v  = 1'b0;
      o_gnt_oh = '0;
      w_start  = (ARB_MODE == ARB_RR) ? int'(i_rr_ptr) : 0;
      for (int i = NUM_M - 1; i >= 0; i--) begin
         if (i_req[(w_start + i) % NUM_M] && (ARB_MODE == ARB_RR || !o_gnt_v)) begin
            o_gnt_id = IDW'((w_start + i) % NUM_M);
            o_gnt_v  = 1'b1;
         end
      end
      for (int k = 0; k < NUM_M; k++)
         o_gnt_oh[k] = o_gnt_v && (o_gnt_id == IDW'(k));
   end

endmodule

// File: rtl/rib_xbar.sv
// Parametrised RIB interconnect: NUM_M masters to NUM_S slaves, one transfer in flight,
// with grant locking for multi-cycle slaves, starvation release and decode-error response.
module rib_xbar
   import rib_pkg::*;
#(
   parameter int            NUM_M    = 3,
   parameter int            NUM_S    = 5,
   parameter int            AW       = 32,
   parameter int            DW       = 32,
   parameter int            SEL_W    = 4,
   parameter int            ARB_MODE = ARB_FIXED,
   parameter int            MAX_HOLD = 16,
   parameter logic [DW-1:0] ERR_DATA = 32'hdeadbeef
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M*AW-1:0] m_addr_i,
   input  logic [NUM_M*DW-1:0] m_data_i,
   input  logic [NUM_M-1:0]    m_req_i,
   input  logic [NUM_M-1:0]    m_we_i,
   output logic [NUM_M*DW-1:0] m_data_o,
   output logic [NUM_M-1:0]    m_ack_o,
   output logic [NUM_M-1:0]    hold_o,
   output logic                err_o,
   output logic [NUM_S*AW-1:0] s_addr_o,
   output logic [NUM_S*DW-1:0] s_data_o,
   output logic [NUM_S-1:0]    s_req_o,
   output logic [NUM_S-1:0]    s_we_o,
   input  logic [NUM_S*DW-1:0] s_data_i,
   input  logic [NUM_S-1:0]    s_ack_i
);

   localparam int IDW = rib_clog2(NUM_M);
   localparam int HCW = rib_clog2(MAX_HOLD + 1);

   logic             r_lock_v;
   logic [IDW-1:0]   r_lock_id;
   logic [IDW-1:0]   r_rr_ptr;
   logic [HCW-1:0]   r_hold_cnt;

   logic [NUM_M-1:0] w_arb_oh;
   logic [IDW-1:0]   w_arb_id;
   logic             w_arb_v;
   logic [NUM_M-1:0] w_gnt_oh;
   logic [IDW-1:0]   w_gnt_id;
   logic             w_gnt_v;
   logic [AW-1:0]    w_g_addr;
   logic [DW-1:0]    w_g_wdata;
   logic             w_g_req;
   logic             w_g_we;
   logic             w_act;
   logic [SEL_W-1:0] w_sel;
   logic             w_dec_ok;
   logic             w_s_ack;
   logic [DW-1:0]    w_s_rdata;
   logic             w_m_ack;
   logic [DW-1:0]    w_rdata;
   logic             w_others;
   logic             w_expire;

   function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] id);
      return (int'(id) == NUM_M - 1) ? '0 : id + 1'b1;
   endfunction

   rib_arb #(.NUM_M(NUM_M), .ARB_MODE(ARB_MODE), .IDW(IDW)) u_arb (
      .i_req    (m_req_i),
      .i_rr_ptr (r_rr_ptr),
      .o_gnt_oh (w_arb_oh),
      .o_gnt_id (w_arb_id),
      .o_gnt_v  (w_arb_v)
   );

   assign w_gnt_v  = r_lock_v | w_arb_v;
   assign w_gnt_id = r_lock_v ? r_lock_id : w_arb_id;

   always_comb begin
      w_gnt_oh  = '0;
      w_g_addr  = '0;
      w_g_wdata = '0;
      w_g_req   = 1'b0;
      w_g_we    = 1'b0;
      for (int k = 0; k < NUM_M; k++) begin
         w_gnt_oh[k] = r_lock_v ? (r_lock_id == IDW'(k)) : w_arb_oh[k];
         if (w_gnt_oh[k]) begin
            w_g_addr  = m_addr_i[k*AW +: AW];
            w_g_wdata = m_data_i[k*DW +: DW];
            w_g_req   = m_req_i[k];
            w_g_we    = m_we_i[k];
         end
      end
   end

   // A locked owner that dropped its request is not a transfer this cycle.
   assign w_act    = w_gnt_v & (w_g_req == RIB_REQ);
   assign w_sel    = w_g_addr[AW-1 -: SEL_W];
   assign w_dec_ok = int'(w_sel) < NUM_S;
   assign w_others = |(m_req_i & ~w_gnt_oh);

   always_comb begin
      s_req_o   = '0;
      s_we_o    = '0;
      s_addr_o  = '0;
      s_data_o  = '0;
      w_s_ack   = 1'b0;
      w_s_rdata = '0;
      for (int j = 0; j < NUM_S; j++) begin
         if (w_act) begin
            s_addr_o[j*AW +: AW] = w_g_addr;
            s_data_o[j*DW +: DW] = w_g_wdata;
         end
         if (w_act && w_sel == SEL_W'(j)) begin
            s_req_o[j] = RIB_REQ;
            s_we_o[j]  = (w_g_we == RIB_WE);
            w_s_ack    = s_ack_i[j];
            w_s_rdata  = s_data_i[j*DW +: DW];
         end
      end
   end

   assign w_m_ack = w_act & (w_dec_ok ? w_s_ack : 1'b1);
   assign w_rdata = w_dec_ok ? w_s_rdata : ERR_DATA;
   assign err_o   = w_act & ~w_dec_ok;

   always_comb begin
      m_ack_o  = '0;
      m_data_o = '0;
      hold_o   = '0;
      for (int k = 0; k < NUM_M; k++) begin
         m_ack_o[k] = w_m_ack & w_gnt_oh[k];
         hold_o[k]  = m_req_i[k] & ~w_gnt_oh[k];
         if (w_act && w_gnt_oh[k]) m_data_o[k*DW +: DW] = w_rdata;
      end
   end

   assign w_expire = (ARB_MODE == ARB_RR) && (MAX_HOLD != 0) && r_lock_v && w_others &&
                     (r_hold_cnt == HCW'(MAX_HOLD - 1));

   // Ack takes precedence over starvation expiry; the counter saturates when unused.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock_v   <= 1'b0;
         r_lock_id  <= '0;
         r_rr_ptr   <= '0;
         r_hold_cnt <= '0;
      end else if (w_m_ack) begin
         r_lock_v   <= 1'b0;
         r_hold_cnt <= '0;
         if (ARB_MODE == ARB_RR) r_rr_ptr <= f_next(w_gnt_id);
      end else if (w_act) begin
         if (w_expire) begin
            r_lock_v   <= 1'b0;
            r_hold_cnt <= '0;
            r_rr_ptr   <= f_next(r_lock_id);
         end else begin
            r_lock_v  <= 1'b1;
            r_lock_id <= w_gnt_id;
            if (r_lock_v && w_others && !(&r_hold_cnt)) r_hold_cnt <= r_hold_cnt + 1'b1;
         end
      end else begin
         r_lock_v   <= 1'b0;
         r_hold_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_rib_xbar.sv
// Bench for rib_xbar: a fixed-priority and a round-robin (MAX_HOLD=4) instance share stimulus
// and are compared every cycle against a transfer-level model, plus hand-computed pins.
module tb_rib_xbar;

   localparam int NM = 3;
   localparam int NS = 5;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MODE [2] = '{0, 1};
   localparam int MAXH [2] = '{16, 4};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NM*AW-1:0] m_addr;
   logic [NM*DW-1:0] m_wdata;
   logic [NM-1:0]    m_req;
   logic [NM-1:0]    m_we;
   logic [NS*DW-1:0] s_rdata;
   logic [NS-1:0]    s_ack;

   logic [NM*DW-1:0] o_mdata [2];
   logic [NM-1:0]    o_mack  [2];
   logic [NM-1:0]    o_hold  [2];
   logic             o_err   [2];
   logic [NS*AW-1:0] o_saddr [2];
   logic [NS*DW-1:0] o_sdata [2];
   logic [NS-1:0]    o_sreq  [2];
   logic [NS-1:0]    o_swe   [2];

   rib_xbar #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .SEL_W(4), .ARB_MODE(0), .MAX_HOLD(16),
              .ERR_DATA(32'hdeadbeef)) u_fix (
      .clk(clk), .rst(rst), .m_addr_i(m_addr), .m_data_i(m_wdata), .m_req_i(m_req), .m_we_i(m_we),
      .m_data_o(o_mdata[0]), .m_ack_o(o_mack[0]), .hold_o(o_hold[0]), .err_o(o_err[0]),
      .s_addr_o(o_saddr[0]), .s_data_o(o_sdata[0]), .s_req_o(o_sreq[0]), .s_we_o(o_swe[0]),
      .s_data_i(s_rdata), .s_ack_i(s_ack));

   rib_xbar #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .SEL_W(4), .ARB_MODE(1), .MAX_HOLD(4),
              .ERR_DATA(32'hdeadbeef)) u_rr (
      .clk(clk), .rst(rst), .m_addr_i(m_addr), .m_data_i(m_wdata), .m_req_i(m_req), .m_we_i(m_we),
      .m_data_o(o_mdata[1]), .m_ack_o(o_mack[1]), .hold_o(o_hold[1]), .err_o(o_err[1]),
      .s_addr_o(o_saddr[1]), .s_data_o(o_sdata[1]), .s_req_o(o_sreq[1]), .s_we_o(o_swe[1]),
      .s_data_i(s_rdata), .s_ack_i(s_ack));

   int n_chk = 0;
   int n_err = 0;
   bit run_chk = 1'b0;

   // Model state: current owner of an unfinished transfer, round-robin start, waited cycles.
   int lk_v  [2] = '{0, 0};
   int lk_id [2] = '{0, 0};
   int rr    [2] = '{0, 0};
   int hc    [2] = '{0, 0};

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic int pick(input int d);
      int g;
      g = -1;
      if (lk_v[d] != 0) return lk_id[d];
      if (MODE[d] == 0) begin
         for (int k = 0; k < NM; k++) if (m_req[k]) g = k;
      end else begin
         for (int i = 0; i < NM && g < 0; i++) if (m_req[(rr[d] + i) % NM]) g = (rr[d] + i) % NM;
      end
      return g;
   endfunction

   task automatic calc(input int d, output int g, output bit act,
                       output logic [NM*DW-1:0] md, output logic [NM-1:0] ma, output logic [NM-1:0] ho,
                       output logic er, output logic [NS*AW-1:0] sa, output logic [NS*DW-1:0] sd,
                       output logic [NS-1:0] sr, output logic [NS-1:0] sw);
      logic [AW-1:0] a;
      int sel;
      g = pick(d);
      act = 1'b0;
      if (g >= 0) act = m_req[g];
      md = '0; ma = '0; ho = '0; er = 1'b0; sa = '0; sd = '0; sr = '0; sw = '0;
      for (int k = 0; k < NM; k++) ho[k] = m_req[k] && (k != g);
      if (act) begin
         a = m_addr[g*AW +: AW];
         sel = int'(a[31:28]);
         for (int s = 0; s < NS; s++) begin
            sa[s*AW +: AW] = a;
            sd[s*DW +: DW] = m_wdata[g*DW +: DW];
         end
         if (sel < NS) begin
            sr[sel] = 1'b1;
            sw[sel] = m_we[g];
            ma[g] = s_ack[sel];
            md[g*DW +: DW] = s_rdata[sel*DW +: DW];
         end else begin
            ma[g] = 1'b1;
            md[g*DW +: DW] = 32'hdeadbeef;
            er = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      int g; bit act; logic [NM*DW-1:0] md; logic [NM-1:0] ma, ho; logic er;
      logic [NS*AW-1:0] sa; logic [NS*DW-1:0] sd; logic [NS-1:0] sr, sw;
      if (run_chk) begin
         for (int d = 0; d < 2; d++) begin
            calc(d, g, act, md, ma, ho, er, sa, sd, sr, sw);
            chk($sformatf("d%0d m_data", d), o_mdata[d], md);
            chk($sformatf("d%0d m_ack", d), o_mack[d], ma);
            chk($sformatf("d%0d hold", d), o_hold[d], ho);
            chk($sformatf("d%0d err", d), o_err[d], er);
            chk($sformatf("d%0d s_addr", d), o_saddr[d], sa);
            chk($sformatf("d%0d s_data", d), o_sdata[d], sd);
            chk($sformatf("d%0d s_req", d), o_sreq[d], sr);
            chk($sformatf("d%0d s_we", d), o_swe[d], sw);
         end
      end
   end

   always @(posedge clk) begin
      int g; bit act; bit others; logic [NM*DW-1:0] md; logic [NM-1:0] ma, ho; logic er;
      logic [NS*AW-1:0] sa; logic [NS*DW-1:0] sd; logic [NS-1:0] sr, sw;
      for (int d = 0; d < 2; d++) begin
         calc(d, g, act, md, ma, ho, er, sa, sd, sr, sw);
         others = 1'b0;
         for (int k = 0; k < NM; k++) if (m_req[k] && k != g) others = 1'b1;
         if (rst) begin
            lk_v[d] <= 0; lk_id[d] <= 0; rr[d] <= 0; hc[d] <= 0;
         end else if (act && ma[g]) begin
            lk_v[d] <= 0; hc[d] <= 0;
            if (MODE[d] == 1) rr[d] <= (g + 1) % NM;
         end else if (act) begin
            if (lk_v[d] != 0 && others && MODE[d] == 1 && MAXH[d] != 0 && hc[d] == MAXH[d] - 1) begin
               lk_v[d] <= 0; hc[d] <= 0; rr[d] <= (lk_id[d] + 1) % NM;
            end else begin
               lk_v[d] <= 1; lk_id[d] <= g;
               if (lk_v[d] != 0 && others) hc[d] <= hc[d] + 1;
            end
         end else begin
            lk_v[d] <= 0; hc[d] <= 0;
         end
      end
   end

   task automatic pin(input string nm, input int d, input logic [NM-1:0] e_ack,
                      input logic [NM-1:0] e_hold, input logic [NS-1:0] e_sreq);
      int g; bit act; logic [NM*DW-1:0] md; logic [NM-1:0] ma, ho; logic er;
      logic [NS*AW-1:0] sa; logic [NS*DW-1:0] sd; logic [NS-1:0] sr, sw;
      calc(d, g, act, md, ma, ho, er, sa, sd, sr, sw);
      chk({nm, "_model_ack"}, ma, e_ack);
      chk({nm, "_model_hold"}, ho, e_hold);
      chk({nm, "_model_sreq"}, sr, e_sreq);
      chk({nm, "_ack"}, o_mack[d], e_ack);
      chk({nm, "_hold"}, o_hold[d], e_hold);
      chk({nm, "_sreq"}, o_sreq[d], e_sreq);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; m_req = '0; m_we = '0; s_ack = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic set_m(input int k, input logic [AW-1:0] a);
      m_addr[k*AW +: AW] = a;
      m_wdata[k*DW +: DW] = 32'ha000_0000 + 32'(k);
   endtask

   logic [NM-1:0] rot [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

   initial begin
      rst = 1'b1; m_addr = '0; m_wdata = '0; m_req = '0; m_we = '0; s_ack = '0; s_rdata = '0;
      for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = 32'h1111_1111 * 32'(s + 1);
      step(); step();
      run_chk = 1'b1;
      @(negedge clk);
      pin("reset", 0, 3'b000, 3'b000, 5'b00000);
      chk("reset_data", o_mdata[1], '0);
      rst = 1'b0;
      step();

      // All three masters hit slave 1 together with a same-cycle ack.
      for (int k = 0; k < NM; k++) set_m(k, 32'h1000_0000);
      m_req = 3'b111; m_we = 3'b101; s_ack = 5'b00010;
      @(negedge clk);
      pin("fix_prio", 0, 3'b100, 3'b011, 5'b00010);
      chk("fix_data", o_mdata[0], {32'h2222_2222, 64'h0});
      chk("fix_we", o_swe[0], 5'b00010);
      pin("rr_first", 1, 3'b001, 3'b110, 5'b00010);
      step();
      do_reset();

      m_req = 3'b111; s_ack = 5'b00010;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         pin($sformatf("rr_rot%0d", c), 1, rot[c], ~rot[c], 5'b00010);
         step();
      end
      do_reset();

      // Three-cycle slave: the owner keeps the grant although m2 requests.
      set_m(0, 32'h1000_0000); set_m(2, 32'h2000_0000);
      m_req = 3'b001; s_ack = 5'b00000;
      @(negedge clk); pin("lk_a", 1, 3'b000, 3'b000, 5'b00010); step();
      m_req = 3'b101;
      @(negedge clk); pin("lk_b", 1, 3'b000, 3'b100, 5'b00010);
      pin("lk_b_fix", 0, 3'b000, 3'b100, 5'b00010); step();
      s_ack = 5'b00010;
      @(negedge clk); pin("lk_c", 1, 3'b001, 3'b100, 5'b00010); step();
      m_req = 3'b100; s_ack = 5'b00100;
      @(negedge clk); pin("lk_d", 1, 3'b100, 3'b000, 5'b00100); step();
      m_req = 3'b000; s_ack = 5'b00000;
      step();

      // Unmapped slave index 7.
      set_m(1, 32'h7000_0000); m_req = 3'b010; m_we = 3'b010;
      @(negedge clk);
      pin("dec_err", 0, 3'b010, 3'b000, 5'b00000);
      chk("dec_err_flag", o_err[0], 1'b1);
      chk("dec_err_data", o_mdata[0], {32'h0, 32'hdeadbeef, 32'h0});
      chk("dec_err_we", o_swe[0], 5'b00000);
      step();
      do_reset();

      // Slave never acks; m1 waits until the round-robin instance releases the lock.
      set_m(0, 32'h1000_0000); set_m(1, 32'h3000_0000);
      m_req = 3'b011;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         pin($sformatf("starve%0d", c), 1, 3'b000, (c < 5) ? 3'b010 : 3'b001,
             (c < 5) ? 5'b00010 : 5'b01000);
         pin($sformatf("starve_fix%0d", c), 0, 3'b000, 3'b001, 5'b01000);
         step();
      end
      do_reset();

      // Reset during a locked transfer; a late ack must reach nobody.
      m_req = 3'b001;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; m_req = 3'b000; s_ack = 5'b11111;
      @(negedge clk);
      pin("rst_late", 1, 3'b000, 3'b000, 5'b00000);
      pin("rst_late_fix", 0, 3'b000, 3'b000, 5'b00000);
      step();
      m_req = 3'b010; s_ack = 5'b01000;
      @(negedge clk);
      pin("rst_new", 1, 3'b010, 3'b000, 5'b01000);
      pin("rst_new_fix", 0, 3'b010, 3'b000, 5'b01000);
      step();
      m_req = 3'b000; s_ack = 5'b00000;
      step();

      run_chk = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
